// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Each granted op is held on the ALU for a per-op cycle count and returned on one tagged response.
module alu_arbiter #(
  parameter int unsigned N          = 32,
  parameter int unsigned NREQ       = 2,
  parameter int unsigned MULDIV_LAT = 4,
  localparam int unsigned IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*6-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic [5:0]        alu_control,
  input  logic [N-1:0]      alu_salida,
  input  logic [3:0]        alu_flags
);

  localparam int unsigned CW = $clog2(MULDIV_LAT + 1);

  localparam logic [5:0] OpAdd = 6'b000001;
  localparam logic [5:0] OpSub = 6'b000010;
  localparam logic [5:0] OpDiv = 6'b000100;
  localparam logic [5:0] OpMul = 6'b000101;
  localparam logic [5:0] OpAnd = 6'b000110;
  localparam logic [5:0] OpOr  = 6'b000111;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [5:0]      op_q, op_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    res_q, res_d;
  logic [3:0]      flags_q, flags_d;
  logic            err_q, err_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [NREQ-1:0] grant_oh;
  int unsigned     cand;
  logic [N-1:0]    sel_a, sel_b;
  logic [5:0]      sel_op;
  logic            sel_legal, sel_err, sel_muldiv;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(ptr_q) + k) % NREQ;
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found                = 1'b1;
        grant_idx                  = cand[IDW-1:0];
        grant_oh[cand[IDW-1:0]]    = 1'b1;
      end
    end
  end

  assign sel_a  = req_a[32'(grant_idx)*N +: N];
  assign sel_b  = req_b[32'(grant_idx)*N +: N];
  assign sel_op = req_op[32'(grant_idx)*6 +: 6];

  always_comb begin
    unique case (sel_op)
      OpAdd, OpSub, OpDiv, OpMul, OpAnd, OpOr: sel_legal = 1'b1;
      default:                                 sel_legal = 1'b0;
    endcase
  end

  assign sel_muldiv = (sel_op == OpDiv) || (sel_op == OpMul);
  assign sel_err    = !sel_legal || ((sel_op == OpDiv) && (sel_b == '0));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (grant_found) state_d = sel_err ? StResp : StExec;
      StExec: if (cnt_q == CW'(1)) state_d = StResp;
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready   = '0;
    rsp_valid   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = '0;
    unique case (state_q)
      StIdle: req_ready = grant_oh;
      StExec: begin
        alu_a       = a_q;
        alu_b       = b_q;
        alu_control = op_q;
      end
      StResp: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;

  always_comb begin
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          a_d   = sel_a;
          b_d   = sel_b;
          op_d  = sel_op;
          id_d  = grant_idx;
          ptr_d = (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
          if (sel_err) begin
            res_d   = '0;
            flags_d = '0;
            err_d   = 1'b1;
          end else begin
            cnt_d = sel_muldiv ? CW'(MULDIV_LAT) : CW'(1);
            err_d = 1'b0;
          end
        end
      end
      StExec: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d = alu_salida;
          // Only add/sub produce meaningful flags for the consumer.
          flags_d = ((op_q == OpAdd) || (op_q == OpSub)) ? alu_flags : 4'b0000;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic against a behavioural model,
// with a mock ALU attached to the arbiter's ALU port.
module tb_alu_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 2;
  localparam int LAT  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic [NREQ*6-1:0] req_op;
  logic              rsp_valid, rsp_ready;
  logic [0:0]        rsp_id;
  logic [N-1:0]      rsp_result;
  logic [3:0]        rsp_flags;
  logic              rsp_err;
  logic [N-1:0]      alu_a, alu_b, alu_salida;
  logic [5:0]        alu_control;
  logic [3:0]        alu_flags;

  logic [N-1:0] ta [NREQ];
  logic [N-1:0] tbv[NREQ];
  logic [5:0]   top[NREQ];

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int           m_ptr;
  logic [N-1:0] e_res;
  logic [3:0]   e_fl;
  logic         e_err;
  logic [5:0]   e_ctl;
  int           e_lat, e_act, e_id;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N), .NREQ(NREQ), .MULDIV_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_control(alu_control),
    .alu_salida (alu_salida),
    .alu_flags  (alu_flags)
  );

  // Returns {N,Z,C,V, result}
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [5:0] op);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      6'd1: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      6'd2: begin
        r = a - b;
        c = (a >= b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      6'd4:    r = (b == 0) ? 32'd0 : a / b;
      6'd5:    r = a * b;
      6'd6:    r = a & b;
      6'd7:    r = a | b;
      default: r = 32'd0;
    endcase
    return {r[31], (r == 0), c, v, r};
  endfunction

  always_comb {alu_flags, alu_salida} = alu_fn(alu_a, alu_b, alu_control);

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N]  = ta[i];
      req_b[i*N +: N]  = tbv[i];
      req_op[i*6 +: 6] = top[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: pick grant, advance pointer, derive the expected response.
  task automatic grant_step(input logic [NREQ-1:0] vmask, output int g);
    logic [35:0] r;
    logic        legal;
    logic [5:0]  op;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (g < 0 && vmask[idx]) g = idx;
    end
    @(negedge clk);
    req_valid = vmask;
    #1;
    chk("grant", req_ready, 64'(1) << g);
    m_ptr = (g + 1) % NREQ;
    op    = top[g];
    legal = (op == 1) || (op == 2) || (op == 4) || (op == 5) || (op == 6) || (op == 7);
    e_err = !legal || (op == 4 && tbv[g] == 0);
    r     = alu_fn(ta[g], tbv[g], op);
    e_res = e_err ? '0 : r[31:0];
    e_fl  = (e_err || !(op == 1 || op == 2)) ? 4'b0 : r[35:32];
    e_lat = e_err ? 1 : ((op == 4 || op == 5) ? 1 + LAT : 2);
    e_act = e_lat - 1;
    e_ctl = e_err ? 6'd0 : op;
    e_id  = g;
    @(negedge clk);
    req_valid = '0;
    #1;
  endtask

  task automatic check_fields(input string tag);
    chk({tag, "_id"}, rsp_id, e_id);
    chk({tag, "_result"}, rsp_result, e_res);
    chk({tag, "_flags"}, rsp_flags, e_fl);
    chk({tag, "_err"}, rsp_err, e_err);
  endtask

  // Called one cycle after the handshake edge; runs until the response is consumed.
  task automatic finish_rsp(input int g, input int hold);
    int         cyc = 1;
    int         act = 0;
    logic [5:0] ctl = '0;
    logic       ab_ok = 1'b1;
    while (rsp_valid !== 1'b1 && cyc < 50) begin
      if (alu_control != 0) begin
        act++;
        ctl = alu_control;
        if (alu_a !== ta[g] || alu_b !== tbv[g]) ab_ok = 1'b0;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("latency", cyc, e_lat);
    chk("alu_cycles", act, e_act);
    chk("alu_ctl", ctl, e_ctl);
    chk("alu_operands", ab_ok, 1'b1);
    check_fields("rsp");
    req_valid = '1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_no_grant", req_ready, '0);
      check_fields("hold");
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_no_grant", req_ready, '0);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = '0;
    #1;
    chk("rsp_dropped", rsp_valid, 1'b0);
  endtask

  task automatic txn(input logic [NREQ-1:0] vmask, input int hold);
    int g;
    grant_step(vmask, g);
    finish_rsp(g, hold);
  endtask

  initial begin
    int         g;
    logic       quiet;
    logic [5:0] ops[10] = '{6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7, 6'd3, 6'd0, 6'd8, 6'd63};

    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    m_ptr     = 0;
    ta[0] = 32'h7FFF_FFFF; tbv[0] = 32'd1; top[0] = 6'b000001;
    ta[1] = 32'd6;         tbv[1] = 32'd7; top[1] = 6'b000101;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_alu_control", alu_control, 6'd0);
    chk("rst_alu_a", alu_a, '0);
    chk("rst_rsp_result", rsp_result, '0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_flags", rsp_flags, 4'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters active: add overflow on r0, mul on r1, alternating grants.
    repeat (4) txn(2'b11, 0);
    chk("add_overflow_result", 64'(alu_fn(32'h7FFF_FFFF, 32'd1, 6'd1)), {4'b1001, 32'h8000_0000});

    // Divide by zero and an illegal code never reach the ALU.
    ta[0] = 32'd10; tbv[0] = 32'd0; top[0] = 6'b000100;
    txn(2'b01, 0);
    top[1] = 6'b000011;
    txn(2'b10, 5);

    // Reset during a div in progress: no response, pointer returns to r0.
    ta[0] = 32'd100; tbv[0] = 32'd5; top[0] = 6'b000100;
    grant_step(2'b01, g);
    chk("div_exec_ctl", alu_control, 6'b000100);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", alu_control, 6'd0);
    chk("midrst_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b0) quiet = 1'b0;
    end
    chk("midrst_no_rsp", quiet, 1'b1);
    top[0] = 6'b000110; ta[0] = 32'hF0F0_1234; tbv[0] = 32'h0FF0_FFFF;
    top[1] = 6'b000111;
    txn(2'b11, 1);

    // Random traffic.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        top[i] = ops[$urandom_range(0, 9)];
        ta[i]  = $urandom;
        tbv[i] = ($urandom_range(0, 3) == 0) ? ta[i] : $urandom;
        if (top[i] == 6'd4) tbv[i] = 32'($urandom_range(0, 3));
      end
      txn(2'($urandom_range(1, 3)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
